// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes, ALUOp codes, opcode classes.
// S_JMP only exists when MULTI_CYCLE_CTRL_JUMP_EN is defined.
package mc_ctrl_pkg;

  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_WB_LW    = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EX_R     = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_EX_I     = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_BR       = 4'd10;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
  localparam logic [3:0] S_JMP      = 4'd11;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [7:0] ALUOP_ADD   = 8'h23;
  localparam logic [7:0] ALUOP_RTYPE = 8'h00;
  localparam logic [7:0] ALUOP_BEQ   = 8'h04;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_MEM,
    CLS_IMM,
    CLS_BR,
    CLS_JMP,
    CLS_ILL
  } op_class_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [7:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier, zero latency, no flow control.
// Opcode 02 classifies as a jump only under MULTI_CYCLE_CTRL_JUMP_EN; otherwise it is illegal.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output op_class_e  op_class_o
);

  always_comb begin
    case (op_i)
      OP_RTYPE:        op_class_o = CLS_R;
      OP_LW, OP_SW:    op_class_o = CLS_MEM;
      OP_ADDI, OP_SLTI: op_class_o = CLS_IMM;
      OP_BEQ:          op_class_o = CLS_BR;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      OP_J:            op_class_o = CLS_JMP;
`endif
      default:         op_class_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM; 3-5 cycles per instruction, stalls in IF/MEM_RD/MEM_WR until mem_ready_i.
// Optional jump state enabled by MULTI_CYCLE_CTRL_JUMP_EN.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [7:0] ALUOp_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  logic [3:0] state_q, state_d;
  op_class_e  op_class;
  ctrl_t      ctrl;
  logic       illegal;

  mc_op_decode u_op_decode (
    .op_i       (op_i),
    .op_class_o (op_class)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:       state_d = mem_ready_i ? S_ID : S_IF;
      S_ID: begin
        case (op_class)
          CLS_R:   state_d = S_EX_R;
          CLS_MEM: state_d = S_MEM_ADDR;
          CLS_IMM: state_d = S_EX_I;
          CLS_BR:  state_d = S_BR;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
          CLS_JMP: state_d = S_JMP;
`endif
          default: state_d = S_IF;
        endcase
      end
      S_MEM_ADDR: state_d = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready_i ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready_i ? S_IF : S_MEM_WR;
      S_EX_R:     state_d = S_WB_R;
      S_EX_I:     state_d = S_WB_I;
      // Write-back, branch, jump and any corrupted encoding all return to fetch.
      default:    state_d = S_IF;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALUOP_ADD;
    illegal     = 1'b0;
    case (state_q)
      S_IF: begin
        // While reset is held only the fetch mux defaults are visible.
        ctrl.mem_read  = rst_i;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready_i & rst_i;
        ctrl.pc_write  = mem_ready_i & rst_i;
      end
      S_ID: begin
        ctrl.alu_src_b = 2'b11;
        illegal        = (op_class == CLS_ILL);
      end
      S_MEM_ADDR: ctrl.alu_src_b = 2'b10;
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EX_R: begin
        ctrl.alu_op    = ALUOP_RTYPE;
        ctrl.alu_src_a = 1'b1;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_EX_I: begin
        ctrl.alu_op    = {2'b00, op_i};
        ctrl.alu_src_b = 2'b10;
      end
      S_WB_I: ctrl.reg_write = 1'b1;
      S_BR: begin
        ctrl.alu_op        = ALUOP_BEQ;
        ctrl.alu_src_a     = 1'b1;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign i_or_d_o        = ctrl.i_or_d;
  assign ir_write_o      = ctrl.ir_write;
  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign reg_write_o     = ctrl.reg_write;
  assign reg_dst_o       = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign pc_source_o     = ctrl.pc_source;
  assign ALUOp_o         = ctrl.alu_op;
  assign state_o         = state_q;
  assign illegal_o       = illegal;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction expected state/output sequences built from opcode rules.
module tb_multi_cycle_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       mem_ready_i;
  logic       mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [7:0] ALUOp_o;
  logic [3:0] state_o;
  logic [22:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  multi_cycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .i_or_d_o(i_or_d_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o),
    .ALUOp_o(ALUOp_o), .state_o(state_o), .illegal_o(illegal_o)
  );

  assign obs = {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o,
                reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, pc_source_o,
                ALUOp_o, illegal_o};

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  step_t plan[$];

  function automatic bit is_legal(input logic [5:0] op);
    if (op inside {6'h00, 6'h04, 6'h08, 6'h0A, 6'h23, 6'h2B}) return 1'b1;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
    if (op == 6'h02) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Expected control word for one cycle, in the same bit order as obs.
  function automatic logic [22:0] expv(input logic [3:0] st, input logic rdy,
                                       input logic [5:0] op, input logic rst);
    logic mr, mw, iod, irw, pcw, pcc, rw, rd, m2r, asa, ill;
    logic [1:0] asb, pcs;
    logic [7:0] aop;
    {mr, mw, iod, irw, pcw, pcc, rw, rd, m2r, asa, ill} = '0;
    asb = 2'b00;
    pcs = 2'b00;
    aop = 8'h23;
    case (st)
      S_IF:       begin mr = rst; asb = 2'b01; irw = rdy & rst; pcw = rdy & rst; end
      S_ID:       begin asb = 2'b11; ill = !is_legal(op); end
      S_MEM_ADDR: asb = 2'b10;
      S_MEM_RD:   begin mr = 1'b1; iod = 1'b1; end
      S_WB_LW:    begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WR:   begin mw = 1'b1; iod = 1'b1; end
      S_EX_R:     begin aop = 8'h00; asa = 1'b1; end
      S_WB_R:     begin rw = 1'b1; rd = 1'b1; end
      S_EX_I:     begin aop = {2'b00, op}; asb = 2'b10; end
      S_WB_I:     rw = 1'b1;
      S_BR:       begin aop = 8'h04; asa = 1'b1; pcc = 1'b1; pcs = 2'b01; end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      S_JMP:      begin pcw = 1'b1; pcs = 2'b10; end
`endif
      default: ;
    endcase
    return {mr, mw, iod, irw, pcw, pcc, rw, rd, m2r, asa, asb, pcs, aop, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Instruction timeline: fetch (with stalls), decode, then the opcode's execution path.
  task automatic build(input logic [5:0] op, input int if_w, input int mem_w);
    for (int i = 0; i < if_w; i++) add(S_IF, 1'b0);
    add(S_IF, 1'b1);
    add(S_ID, rnd_bit());
    case (op)
      6'h00:        begin add(S_EX_R, rnd_bit()); add(S_WB_R, rnd_bit()); end
      6'h08, 6'h0A: begin add(S_EX_I, rnd_bit()); add(S_WB_I, rnd_bit()); end
      6'h04:        add(S_BR, rnd_bit());
      6'h23: begin
        add(S_MEM_ADDR, rnd_bit());
        for (int i = 0; i < mem_w; i++) add(S_MEM_RD, 1'b0);
        add(S_MEM_RD, 1'b1);
        add(S_WB_LW, rnd_bit());
      end
      6'h2B: begin
        add(S_MEM_ADDR, rnd_bit());
        for (int i = 0; i < mem_w; i++) add(S_MEM_WR, 1'b0);
        add(S_MEM_WR, 1'b1);
      end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      6'h02:        add(S_JMP, rnd_bit());
`endif
      default: ;
    endcase
  endtask

  task automatic run_plan(input logic [5:0] op, output int wr, output int mreq);
    string tag;
    wr   = 0;
    mreq = 0;
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk_i);
      #1;
      mem_ready_i = plan[i].rdy;
      if (i == 0) op_i = op;
      @(negedge clk_i);
      tag = $sformatf("op%02h step%0d", op, i);
      chk({tag, " state"}, 32'(state_o), 32'(plan[i].st));
      chk({tag, " ctrl"}, 32'(obs), 32'(expv(plan[i].st, plan[i].rdy, op, 1'b1)));
      if (reg_write_o) wr++;
      if (plan[i].st != S_IF && (mem_read_o || mem_write_o)) mreq++;
    end
    plan.delete();
  endtask

  task automatic do_instr(input logic [5:0] op, input int if_w, input int mem_w);
    int wr, mreq;
    build(op, if_w, mem_w);
    run_plan(op, wr, mreq);
    chk($sformatf("op%02h reg_write pulses", op), 32'(wr),
        (op inside {6'h00, 6'h08, 6'h0A, 6'h23}) ? 32'd1 : 32'd0);
    chk($sformatf("op%02h mem request cycles", op), 32'(mreq),
        (op inside {6'h23, 6'h2B}) ? 32'(mem_w + 1) : 32'd0);
  endtask

  initial begin
    int wr, mreq;
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h3F, 6'h00};

    rst_i       = 1'b0;
    op_i        = 6'h00;
    mem_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset state", 32'(state_o), 32'(S_IF));
    chk("reset ctrl", 32'(obs), 32'(expv(S_IF, 1'b0, 6'h00, 1'b0)));
    mem_ready_i = 1'b1;
    #1;
    chk("reset ctrl ready", 32'(obs), 32'(expv(S_IF, 1'b1, 6'h00, 1'b0)));
    mem_ready_i = 1'b0;
    #1;
    rst_i = 1'b1;

    // Directed: R-type, lw with two memory stalls, beq, illegal, op 02, sw, immediates.
    do_instr(6'h00, 0, 0);
    do_instr(6'h23, 0, 2);
    do_instr(6'h04, 1, 0);
    do_instr(6'h3F, 0, 0);
    do_instr(6'h02, 0, 0);
    do_instr(6'h2B, 2, 1);
    do_instr(6'h08, 0, 0);
    do_instr(6'h0A, 1, 0);

    // Reset asserted while a store waits on memory.
    add(S_IF, 1'b1);
    add(S_ID, 1'b1);
    add(S_MEM_ADDR, 1'b1);
    add(S_MEM_WR, 1'b0);
    run_plan(6'h2B, wr, mreq);
    #1;
    rst_i = 1'b0;
    #1;
    chk("midwait reset state", 32'(state_o), 32'(S_IF));
    chk("midwait reset mem_write", 32'(mem_write_o), 32'd0);
    chk("midwait reset ctrl", 32'(obs), 32'(expv(S_IF, mem_ready_i, op_i, 1'b0)));
    #1;
    rst_i = 1'b1;
    do_instr(6'h00, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op_i, input, 6 bits: instruction opcode, sampled from the instruction register.
REQ-004 SHALL have port mem_ready_i, input, 1 bit: memory has completed the current read/write this cycle.
REQ-005 SHALL have ports mem_read_o and mem_write_o, output, 1 bit each: memory request, held high until mem_ready_i.
REQ-006 SHALL have port i_or_d_o, output, 1 bit: 0 = PC address, 1 = ALUOut address.
REQ-007 SHALL have ports ir_write_o, pc_write_o and pc_write_cond_o, output, 1 bit each: register enables.
REQ-008 SHALL have ports reg_write_o, reg_dst_o and mem_to_reg_o, output, 1 bit each: register file controls.
REQ-009 SHALL have ports alu_src_a_o (1 bit), alu_src_b_o (2 bits) and pc_source_o (2 bits), output: datapath muxes.
REQ-010 SHALL have port ALUOp_o, output, 8 bits: opcode-style code for the existing ALU controller.
REQ-011 SHALL have ports state_o (4 bits) and illegal_o (1 bit), output: current state; one-cycle pulse on an unsupported opcode.

Function
REQ-012 SHALL implement a Moore FSM with states IF, ID, MEM_ADDR, MEM_RD, WB_LW, MEM_WR, EX_R, WB_R, EX_I, WB_I, BR and JMP.
REQ-013 IF SHALL assert mem_read_o, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, ALUOp_o=8'h23 (add) and pc_source_o=00.
REQ-014 In IF, ir_write_o and pc_write_o SHALL be high only in a cycle with mem_ready_i=1; IF SHALL then go to ID, else stay in IF.
REQ-015 ID SHALL drive alu_src_a_o=0, alu_src_b_o=11 and ALUOp_o=8'h23 (branch target), then branch on op_i: 00->EX_R; 23/2B->MEM_ADDR; 08/0A->EX_I; 04->BR; other->IF with illegal_o=1.
REQ-016 EX_R SHALL drive ALUOp_o=8'h00 and alu_src_a_o=1, alu_src_b_o=00; WB_R SHALL drive reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0, then go to IF.
REQ-017 EX_I SHALL drive ALUOp_o equal to op_i zero-extended (8'h08 or 8'h0A) with alu_src_b_o=10; WB_I SHALL drive reg_write_o=1, reg_dst_o=0, then go to IF.
REQ-018 MEM_ADDR SHALL drive ALUOp_o=8'h23 and alu_src_b_o=10, then go to MEM_RD when op=23, else MEM_WR.
REQ-019 MEM_RD and MEM_WR SHALL hold i_or_d_o=1 and the request until mem_ready_i=1; MEM_RD then goes to WB_LW (mem_to_reg_o=1, reg_write_o=1), and MEM_WR goes to IF.
REQ-020 BR SHALL drive ALUOp_o=8'h04, alu_src_a_o=1, pc_write_cond_o=1 and pc_source_o=01, then go to IF.
REQ-021 In every state, outputs not named for that state SHALL be 0; in idle states ALUOp_o SHALL be 8'h23.
REQ-022 Minimum latencies (mem_ready_i tied high) SHALL be: R/I-type 4 cycles, beq 3, sw 4, lw 5; each wait cycle adds 1.
REQ-023 mem_ready_i SHALL be ignored outside IF/MEM_RD/MEM_WR; an unknown state SHALL recover to IF on the next edge.

Reset
REQ-024 rst_i low SHALL force state IF asynchronously, including mid-wait; on that clock, all outputs except IF mux defaults SHALL be 0, and illegal_o SHALL be 0.
REQ-025 The first fetch SHALL begin on the first rising edge after rst_i deasserts.

Configuration
REQ-026 With MULTI_CYCLE_CTRL_JUMP_EN defined, op 02 in ID SHALL go to JMP (pc_write_o=1, pc_source_o=10, 1 cycle), then to IF.
REQ-027 Without MULTI_CYCLE_CTRL_JUMP_EN, JMP SHALL not exist, and op 02 SHALL be illegal (illegal_o pulse, return to IF).

Structure
REQ-028 Shared package mc_ctrl_pkg SHALL hold the state encoding, the opcode constants (00,02,04,08,0A,23,2B) and the ALUOp codes.
REQ-029 Opcode classification SHALL be in combinational sub-module mc_op_decode (op_i -> class); the FSM and the output decode stay in multi_cycle_ctrl.

Verification
REQ-030 With mem_ready_i=1 and op=00 the bench SHALL see state IF,ID,EX_R,WB_R,IF, ALUOp_o=8'h00 only in EX_R, and reg_write_o=1 only in WB_R.
REQ-031 For lw (op=23) with mem_ready_i low for 2 cycles in MEM_RD, the bench SHALL see 7 cycles IF-to-IF, mem_read_o held for 3 cycles and one reg_write_o pulse.
REQ-032 For beq (op=04), the bench SHALL see ALUOp_o=8'h04 and pc_write_cond_o=1 for exactly 1 cycle, followed by IF.
REQ-033 With op=3F, or op=02 without the macro, the bench SHALL see illegal_o=1 for 1 cycle in ID and the next state IF; with the macro, op=02 SHALL give pc_write_o=1 with pc_source_o=10.
REQ-034 rst_i low during MEM_WR with mem_ready_i=0 SHALL give immediate state_o=IF, mem_write_o=0, and the next fetch after release.
